// File: rtl/dpram_copy_dma_if.sv
`default_nettype none
// ============================================================================
// Module   : dpram_copy_dma_if
// Brief    : Port A (read) / port B (write) bus between the copy engine and a
//            dpram_r2w1 instance.
// Revision : 1.0
// ============================================================================
interface dpram_copy_dma_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              a_ce;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_write;
  logic [DATA_W-1:0] a_read;
  logic              b_ce;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_write;

  modport master (
    output a_ce, a_we, a_addr, a_write,
    input  a_read,
    output b_ce, b_we, b_addr, b_write
  );

  modport slave (
    input  a_ce, a_we, a_addr, a_write,
    output a_read,
    input  b_ce, b_we, b_addr, b_write
  );
endinterface
`default_nettype wire

// File: rtl/dpram_copy_dma.sv
`default_nettype none
// ============================================================================
// Module   : dpram_copy_dma
// Brief    : Block copy engine: one RAM read and one RAM write per cycle.
//            Define DPRAM_COPY_DMA_CHECKSUM_EN to add the XOR checksum output.
// Revision : 1.0
// ============================================================================
module dpram_copy_dma #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              aborted,
`ifdef DPRAM_COPY_DMA_CHECKSUM_EN
  output logic [DATA_W-1:0] csum,
`endif
  dpram_copy_dma_if.master  ram
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   c_len_max  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   c_one_len  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_one_addr = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_idx;   // number of reads issued so far
  logic              r_abort_req;
  logic              r_aborted;

  logic              w_accept;
  logic [ADDR_W:0]   w_len_clamped;
  logic              w_last_read;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_b_en;
  logic [DATA_W-1:0] w_rd_data;

  // A new copy may start from IDLE or in the DONE cycle, giving back-to-back copies.
  assign w_accept      = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_len_clamped = (len > c_len_max) ? c_len_max : len;
  assign w_last_read   = (r_idx == (r_len - c_one_len));
  assign w_wr_addr     = r_dst + r_idx[ADDR_W-1:0] - c_one_addr;
  assign w_rd_data     = ram.a_read;

  assign ram.a_we    = 1'b0;
  assign ram.a_write = '0;
  assign ram.b_ce    = w_b_en;
  assign ram.b_we    = w_b_en;
  assign ram.b_write = w_rd_data;

  assign busy    = (r_state == S_READ) || (r_state == S_DRAIN);
  assign done    = (r_state == S_DONE);
  assign aborted = r_aborted;

  always_comb begin
    w_state_nxt = r_state;
    ram.a_ce    = 1'b0;
    ram.a_addr  = '0;
    w_b_en      = 1'b0;
    ram.b_addr  = '0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_nxt = (w_len_clamped == '0) ? S_DRAIN : S_READ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        ram.a_ce   = 1'b1;
        ram.a_addr = r_src + r_idx[ADDR_W-1:0];
        if (r_idx != '0) begin
          w_b_en     = 1'b1;
          ram.b_addr = w_wr_addr;
        end
        if (abort || w_last_read) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_idx != '0) begin
          w_b_en     = 1'b1;
          ram.b_addr = w_wr_addr;
        end
        w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_abort_req <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_src       <= src;
        r_dst       <= dst;
        r_len       <= w_len_clamped;
        r_idx       <= '0;
        r_abort_req <= 1'b0;
        r_aborted   <= 1'b0;
      end else begin
        if (r_state == S_READ) begin
          r_idx <= r_idx + c_one_len;
          if (abort) begin
            r_abort_req <= 1'b1;
          end
        end
        // aborted becomes visible together with the done pulse.
        if (r_state == S_DRAIN) begin
          r_aborted <= r_abort_req;
        end
      end
    end
  end

`ifdef DPRAM_COPY_DMA_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= '0;
    end else if (w_b_en) begin
      r_csum <= r_csum ^ w_rd_data;
    end
  end

  assign csum = r_csum;
`endif

endmodule
`default_nettype wire
